// File: rtl/wb_rr_arbiter_wdt_if.sv
// Wishbone bundle between NUM_MASTERS cores, the round-robin arbiter and the shared slave.
// slave: the arbiter's view of the bundle; master: the surrounding cores plus the slave.
interface wb_rr_arbiter_wdt_if #(
  parameter int NUM_MASTERS = 2,
  parameter int DW          = 32,
  parameter int AW          = 32
);
  logic [AW*NUM_MASTERS-1:0] wbm_adr_i;
  logic [DW*NUM_MASTERS-1:0] wbm_dat_i;
  logic [4*NUM_MASTERS-1:0]  wbm_sel_i;
  logic [NUM_MASTERS-1:0]    wbm_we_i;
  logic [NUM_MASTERS-1:0]    wbm_cyc_i;
  logic [NUM_MASTERS-1:0]    wbm_stb_i;
  logic [3*NUM_MASTERS-1:0]  wbm_cti_i;
  logic [2*NUM_MASTERS-1:0]  wbm_bte_i;
  logic [DW*NUM_MASTERS-1:0] wbm_dat_o;
  logic [NUM_MASTERS-1:0]    wbm_ack_o;
  logic [NUM_MASTERS-1:0]    wbm_err_o;
  logic [NUM_MASTERS-1:0]    wbm_rty_o;

  logic [AW-1:0] wbs_adr_o;
  logic [DW-1:0] wbs_dat_o;
  logic [3:0]    wbs_sel_o;
  logic          wbs_we_o;
  logic          wbs_cyc_o;
  logic          wbs_stb_o;
  logic [2:0]    wbs_cti_o;
  logic [1:0]    wbs_bte_o;
  logic [DW-1:0] wbs_dat_i;
  logic          wbs_ack_i;
  logic          wbs_err_i;
  logic          wbs_rty_i;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );
endinterface

// File: rtl/wb_rr_arbiter_wdt.sv
// Round-robin Wishbone B3 arbiter: one owner per whole cyc tenure, plus a bus watchdog that
// aborts unanswered strobes and returns err to the owner.
module wb_rr_arbiter_wdt #(
  parameter int NUM_MASTERS = 2,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  wb_rr_arbiter_wdt_if.slave     bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t        state;
  logic [GW-1:0] owner;
  logic [GW-1:0] last;
  logic [CW-1:0] count;
  logic          abort_err;

  logic          owner_cyc;
  logic          owner_stb;
  logic          resp;
  logic          expire;
  logic          any_req;
  logic [GW-1:0] winner;
  logic [GW-1:0] idx;

  assign owner_cyc = bus.wbm_cyc_i[owner];
  assign owner_stb = bus.wbm_stb_i[owner];
  assign resp      = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
  assign any_req   = |bus.wbm_cyc_i;
  // A response arriving in the expiry cycle wins over the abort.
  assign expire    = (TIMEOUT > 0) && (state == BUSY) && owner_stb && !resp && (count == LIMIT);

  // Scan from the farthest offset down so the nearest requester after last wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = GW'((int'(last) + i) % NUM_MASTERS);
      if (bus.wbm_cyc_i[idx]) winner = idx;
    end
  end

  // NOTE: every output gets a default before the branches, so no latch is inferred.
  always_comb begin
    bus.wbm_dat_o = {NUM_MASTERS{bus.wbs_dat_i}};
    bus.wbm_ack_o = '0;
    bus.wbm_err_o = '0;
    bus.wbm_rty_o = '0;
    bus.wbs_adr_o = '0;
    bus.wbs_dat_o = '0;
    bus.wbs_sel_o = '0;
    bus.wbs_we_o  = 1'b0;
    bus.wbs_cyc_o = 1'b0;
    bus.wbs_stb_o = 1'b0;
    bus.wbs_cti_o = '0;
    bus.wbs_bte_o = '0;
    if (state == BUSY) begin
      bus.wbs_adr_o        = bus.wbm_adr_i[owner*AW +: AW];
      bus.wbs_dat_o        = bus.wbm_dat_i[owner*DW +: DW];
      bus.wbs_sel_o        = bus.wbm_sel_i[owner*4 +: 4];
      bus.wbs_we_o         = bus.wbm_we_i[owner];
      bus.wbs_cyc_o        = owner_cyc;
      bus.wbs_stb_o        = owner_stb;
      bus.wbs_cti_o        = bus.wbm_cti_i[owner*3 +: 3];
      bus.wbs_bte_o        = bus.wbm_bte_i[owner*2 +: 2];
      bus.wbm_ack_o[owner] = bus.wbs_ack_i;
      bus.wbm_err_o[owner] = bus.wbs_err_i;
      bus.wbm_rty_o[owner] = bus.wbs_rty_i;
    end else if (state == ABORT) begin
      bus.wbm_err_o[owner] = abort_err;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= GW'(NUM_MASTERS - 1);
      grant_o   <= '0;
      count     <= '0;
      abort_err <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      abort_err <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (any_req) begin
            state   <= BUSY;
            owner   <= winner;
            last    <= winner;
            grant_o <= NUM_MASTERS'(1) << winner;
          end
        end
        BUSY: begin
          if (!owner_cyc) begin
            state   <= IDLE;
            grant_o <= '0;
            count   <= '0;
          end else if (expire) begin
            state     <= ABORT;
            timeout_o <= 1'b1;
            abort_err <= 1'b1;
            count     <= '0;
          end else if (TIMEOUT > 0 && owner_stb && !resp) begin
            count <= count + CW'(1);
          end else begin
            count <= '0;
          end
        end
        ABORT: begin
          count <= '0;
          if (!owner_cyc) begin
            state   <= IDLE;
            grant_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
